ddr2_refresh_scheduler: RTL and testbench

//  Generates AUTO REFRESH requests for the DDR2 command arbiter at a tREFI cadence once the controller is ready.

---
 rtl/ddr2_refresh_scheduler.sv | 166 ++++++++++++++++
 tb/tb_ddr2_refresh_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ddr2_refresh_scheduler.sv
// DDR2 auto-refresh scheduler: tREFI cadence, postponed-refresh debt, urgency and tRFC blackout.
// Optional pull-in of refreshes during idle traffic is enabled by defining DDR2_REF_PULLIN_EN.
module ddr2_refresh_scheduler #(
    parameter int TREFI_CLK     = 1560,
    parameter int TRFC_CLK      = 26,
    parameter int MAX_POSTPONE  = 8,
    parameter int URGENT_THRESH = 4,
    parameter int MAX_PULLIN    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready_i,
    input  logic       idle_i,
    input  logic       ref_ack_i,
    output logic       ref_req_o,
    output logic       ref_urgent_o,
    output logic       ref_busy_o,
    output logic [3:0] ref_debt_o,
    output logic       ref_overflow_o
);

    localparam int CW = (TREFI_CLK > 1) ? $clog2(TREFI_CLK) : 1;
    localparam int RW = (TRFC_CLK > 1) ? $clog2(TRFC_CLK) : 1;
    localparam int DW = $clog2(MAX_POSTPONE + 1);
    localparam int PW = $clog2(MAX_PULLIN + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TREFI_CLK - 1);
    localparam logic [RW-1:0] RFC_LAST   = RW'(TRFC_CLK - 1);
    localparam logic [DW-1:0] DEBT_MAX   = DW'(MAX_POSTPONE);
    localparam logic [DW-1:0] DEBT_URG   = DW'(URGENT_THRESH);
    localparam logic [DW-1:0] DEBT_ZERO  = {DW{1'b0}};
    localparam logic [PW-1:0] CREDIT_MAX = PW'(MAX_PULLIN);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RFC = 1'b1} state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [RW-1:0] rfc_cnt_r, rfc_cnt_s;
    logic [DW-1:0] debt_r, debt_s;
    logic          ovf_r, ovf_s;
    logic          expire_s, req_s, accept_s, pull_s;

`ifdef DDR2_REF_PULLIN_EN
    localparam logic [PW-1:0] CREDIT_ZERO = {PW{1'b0}};
    logic [PW-1:0] credit_r, credit_s;

    assign pull_s = ready_i && (state_r == ST_IDLE) && (debt_r == DEBT_ZERO) &&
                    idle_i && (credit_r < CREDIT_MAX);
`else
    logic          idle_unused_s;
    logic [PW-1:0] credit_unused_s;

    assign idle_unused_s   = idle_i;
    assign credit_unused_s = CREDIT_MAX;
    assign pull_s          = 1'b0;
`endif

    assign expire_s = ready_i && (cnt_r == CNT_LAST);
    assign req_s    = (state_r == ST_IDLE) && ((debt_r != DEBT_ZERO) || pull_s);
    assign accept_s = req_s && ref_ack_i;

    // Next-state, interval counter and debt/credit bookkeeping
    always_comb begin
        state_s   = state_r;
        rfc_cnt_s = rfc_cnt_r;
        cnt_s     = cnt_r;
        debt_s    = debt_r;
        ovf_s     = ovf_r;
`ifdef DDR2_REF_PULLIN_EN
        credit_s  = credit_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s   = ST_RFC;
                    rfc_cnt_s = {RW{1'b0}};
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_RFC: begin
                // Blackout always runs to completion, even if ready_i drops
                if (rfc_cnt_r == RFC_LAST) begin
                    state_s   = ST_IDLE;
                    rfc_cnt_s = {RW{1'b0}};
                end else begin
                    rfc_cnt_s = rfc_cnt_r + RW'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                rfc_cnt_s = {RW{1'b0}};
            end
        endcase

        if (!ready_i || expire_s) begin
            cnt_s = {CW{1'b0}};
        end else begin
            cnt_s = cnt_r + CW'(1);
        end

        if (!ready_i) begin
            debt_s = DEBT_ZERO;
`ifdef DDR2_REF_PULLIN_EN
            credit_s = CREDIT_ZERO;
`endif
        end else if (expire_s && accept_s) begin
            debt_s = debt_r;
        end else if (expire_s) begin
`ifdef DDR2_REF_PULLIN_EN
            if (credit_r != CREDIT_ZERO) begin
                credit_s = credit_r - PW'(1);
            end else if (debt_r == DEBT_MAX) begin
                ovf_s = 1'b1;
            end else begin
                debt_s = debt_r + DW'(1);
            end
`else
            if (debt_r == DEBT_MAX) begin
                ovf_s = 1'b1;
            end else begin
                debt_s = debt_r + DW'(1);
            end
`endif
        end else if (accept_s && (debt_r == DEBT_ZERO)) begin
`ifdef DDR2_REF_PULLIN_EN
            credit_s = credit_r + PW'(1);
`else
            debt_s = debt_r;
`endif
        end else if (accept_s) begin
            debt_s = debt_r - DW'(1);
        end else begin
            debt_s = debt_r;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            rfc_cnt_r <= {RW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            debt_r    <= DEBT_ZERO;
            ovf_r     <= 1'b0;
`ifdef DDR2_REF_PULLIN_EN
            credit_r  <= CREDIT_ZERO;
`endif
        end else begin
            state_r   <= state_s;
            rfc_cnt_r <= rfc_cnt_s;
            cnt_r     <= cnt_s;
            debt_r    <= debt_s;
            ovf_r     <= ovf_s;
`ifdef DDR2_REF_PULLIN_EN
            credit_r  <= credit_s;
`endif
        end
    end

    assign ref_req_o      = req_s;
    assign ref_busy_o     = (state_r == ST_RFC);
    assign ref_urgent_o   = (state_r == ST_IDLE) && (debt_r >= DEBT_URG);
    assign ref_debt_o     = 4'(debt_r);
    assign ref_overflow_o = ovf_r;

endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// Directed bench for ddr2_refresh_scheduler with TREFI=100, TRFC=10, MAX_POSTPONE=8, URGENT=4.
// Time reference: cyc counts rising edges; outputs are sampled on the falling edge.
module tb_ddr2_refresh_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ready_i = 1'b0;
    logic       idle_i = 1'b0;
    logic       ref_ack_i = 1'b0;
    logic       ref_req_o, ref_urgent_o, ref_busy_o, ref_overflow_o;
    logic [3:0] ref_debt_o;

    int cyc = 0;
    int c0 = 0;
    int passed = 0;
    int total = 0;
    int t_first, t_prev, nb, n;

    ddr2_refresh_scheduler #(
        .TREFI_CLK(100), .TRFC_CLK(10), .MAX_POSTPONE(8), .URGENT_THRESH(4), .MAX_PULLIN(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ready_i(ready_i), .idle_i(idle_i),
        .ref_ack_i(ref_ack_i), .ref_req_o(ref_req_o), .ref_urgent_o(ref_urgent_o),
        .ref_busy_o(ref_busy_o), .ref_debt_o(ref_debt_o), .ref_overflow_o(ref_overflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance to the falling edge where cyc == c0 + k
    task automatic go(input int k);
        while (cyc < c0 + k) @(negedge clk);
    endtask

    task automatic restart();
        ready_i = 1'b0;
        @(negedge clk);
        ready_i = 1'b1;
        c0 = cyc;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", ref_req_o, 0);
        chk("rst_busy", ref_busy_o, 0);
        chk("rst_debt", ref_debt_o, 0);
        chk("rst_ovf", ref_overflow_o, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: first request after one interval, 10-cycle blackout, next request 100 later
        restart();
        go(99);  chk("t1_req_early", ref_req_o, 0);
        go(100); chk("t1_req", ref_req_o, 1); chk("t1_debt1", ref_debt_o, 1);
        t_first = cyc;
        ref_ack_i = 1'b1; @(negedge clk); ref_ack_i = 1'b0;
        chk("t1_busy", ref_busy_o, 1); chk("t1_debt0", ref_debt_o, 0); chk("t1_req_rfc", ref_req_o, 0);
        nb = 1;
        repeat (15) begin
            @(negedge clk);
            if (ref_busy_o === 1'b1) nb++;
        end
        chk("t1_busy_len", nb, 10);
        n = 0;
        while (ref_req_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("t1_req2_seen", ref_req_o, 1);
        chk("t1_req2_gap", cyc - t_first, 100);

        // 2: debt accrual, urgency, four acks 11 cycles apart
        restart();
        go(100); chk("t2_debt1", ref_debt_o, 1);
        go(200); chk("t2_debt2", ref_debt_o, 2);
        go(300); chk("t2_debt3", ref_debt_o, 3); chk("t2_urg_lo", ref_urgent_o, 0);
        go(400); chk("t2_debt4", ref_debt_o, 4); chk("t2_urg_hi", ref_urgent_o, 1);
        go(450); chk("t2_debt4_hold", ref_debt_o, 4);
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (ref_req_o !== 1'b1 && n < 30) begin @(negedge clk); n++; end
            chk("t2_req_seen", ref_req_o, 1);
            if (k > 0) chk("t2_ack_gap", cyc - t_prev, 11);
            t_prev = cyc;
            ref_ack_i = 1'b1; @(negedge clk); ref_ack_i = 1'b0;
            chk("t2_debt_dec", ref_debt_o, 3 - k);
        end
        n = 0;
        while (ref_busy_o !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("t2_busy_done", ref_busy_o, 0);
        chk("t2_req_drop", ref_req_o, 0);
        chk("t2_urg_drop", ref_urgent_o, 0);

        // 3: saturation at 8 and sticky overflow on the ninth expiry
        restart();
        go(800); chk("t3_debt8", ref_debt_o, 8); chk("t3_ovf_lo", ref_overflow_o, 0);
        go(899); chk("t3_ovf_pre", ref_overflow_o, 0);
        go(900); chk("t3_ovf_hi", ref_overflow_o, 1); chk("t3_debt_sat", ref_debt_o, 8);
        ref_ack_i = 1'b1;
        go(990);
        ref_ack_i = 1'b0;
        chk("t3_drained", ref_debt_o, 0); chk("t3_ovf_sticky", ref_overflow_o, 1);
        chk("t3_req_lo", ref_req_o, 0);

        // 4: ack coincident with expiry, then an ignored ack during RFC
        restart();
        go(200); chk("t4_debt2", ref_debt_o, 2);
        go(299); ref_ack_i = 1'b1; @(negedge clk); ref_ack_i = 1'b0;
        chk("t4_debt_net", ref_debt_o, 2); chk("t4_busy", ref_busy_o, 1);
        go(302); ref_ack_i = 1'b1; @(negedge clk); ref_ack_i = 1'b0;
        chk("t4_ign_debt", ref_debt_o, 2); chk("t4_ign_busy", ref_busy_o, 1);
        go(310);
        chk("t4_rfc_end", ref_busy_o, 0); chk("t4_req_back", ref_req_o, 1); chk("t4_debt_end", ref_debt_o, 2);

        // 5: ready_i drops mid-RFC, blackout still completes
        restart();
        go(400); ref_ack_i = 1'b1; @(negedge clk); ref_ack_i = 1'b0;
        chk("t5_debt3", ref_debt_o, 3); chk("t5_busy", ref_busy_o, 1);
        go(403); ready_i = 1'b0;
        @(negedge clk);
        chk("t5_debt_clr", ref_debt_o, 0); chk("t5_busy_kept", ref_busy_o, 1); chk("t5_req_lo", ref_req_o, 0);
        go(410); chk("t5_busy_last", ref_busy_o, 1);
        go(411); chk("t5_busy_end", ref_busy_o, 0); chk("t5_req_end", ref_req_o, 0);
        go(420); chk("t5_req_later", ref_req_o, 0); chk("t5_ovf_kept", ref_overflow_o, 1);

        // 5b: asynchronous reset in the middle of a blackout
        restart();
        go(200); ref_ack_i = 1'b1; @(negedge clk); ref_ack_i = 1'b0;
        chk("t5b_busy", ref_busy_o, 1); chk("t5b_debt1", ref_debt_o, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5b_busy0", ref_busy_o, 0); chk("t5b_debt0", ref_debt_o, 0);
        chk("t5b_ovf0", ref_overflow_o, 0); chk("t5b_req0", ref_req_o, 0);
        chk("t5b_urg0", ref_urgent_o, 0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef DDR2_REF_PULLIN_EN
        // 6: pull-in credit fills to 8, then absorbs 8 expiries
        restart();
        idle_i = 1'b1; ref_ack_i = 1'b1;
        go(95);
        chk("t6_req_full", ref_req_o, 0); chk("t6_debt0", ref_debt_o, 0);
        ref_ack_i = 1'b0; idle_i = 1'b0;
        go(899); chk("t6_debt_absorb", ref_debt_o, 0);
        go(900); chk("t6_debt1", ref_debt_o, 1); chk("t6_req1", ref_req_o, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
